// File: rtl/tb_dina_map.sv
// TB port-A write mapper: captures A/M systolic result rows and writes them lane-mapped into the
// TB BRAM as a burst of consecutive addresses.
module tb_dina_map #(
  parameter int unsigned X      = 4,
  parameter int unsigned L      = 4,
  parameter int unsigned RSA_DW = 16,
  parameter int unsigned TB_AW  = 10,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [2:0]            TB_dina_sel,
  input  logic                  l_k_0,
  input  logic [TB_AW-1:0]      base_addr,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [X*RSA_DW-1:0]   A_C_dout,
  input  logic                  A_C_valid,
  input  logic [X*RSA_DW-1:0]   M_C_dout,
  input  logic                  M_C_valid,
  output logic                  TB_ena,
  output logic [L-1:0]          TB_wea,
  output logic [TB_AW-1:0]      TB_addra,
  output logic [L*RSA_DW-1:0]   TB_dina,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [1:0] DirIdle = 2'b00;
  localparam logic [1:0] DirPos  = 2'b01;
  localparam logic [1:0] DirNeg  = 2'b10;
  localparam logic [1:0] DirNew  = 2'b11;

  state_e              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic                lk0_q, lk0_d;
  logic [TB_AW-1:0]    base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic                ena_q, ena_d;
  logic [L-1:0]        wea_q, wea_d;
  logic [TB_AW-1:0]    addr_q, addr_d;
  logic [L*RSA_DW-1:0] dina_q, dina_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [X*RSA_DW-1:0] row;
  logic                beat;
  logic                start_ok;
  logic [L*RSA_DW-1:0] dina_map;
  logic [L-1:0]        wea_map;

  assign row  = sel_q[2] ? M_C_dout : A_C_dout;
  assign beat = (state_q == StRun) && (sel_q[2] ? M_C_valid : A_C_valid);
  // busy_q also covers the done cycle, so a start there is rejected
  assign start_ok = (state_q == StIdle) && !busy_q && start &&
                    (TB_dina_sel[1:0] != DirIdle) && (burst_len != '0);

  always_comb begin
    dina_map = '0;
    wea_map  = '0;
    case (sel_q[1:0])
      DirPos: begin
        dina_map = row;
        wea_map  = '1;
      end
      DirNeg: begin
        for (int unsigned i = 0; i < X; i++) begin
          dina_map[i*RSA_DW +: RSA_DW] = row[(X-1-i)*RSA_DW +: RSA_DW];
        end
        wea_map = '1;
      end
      DirNew: begin
        // a new landmark occupies one half of the word, chosen by l_k_0
        if (lk0_q) begin
          dina_map[0 +: 2*RSA_DW] = row[0 +: 2*RSA_DW];
          wea_map                 = L'(4'b0011);
        end else begin
          dina_map[2*RSA_DW +: 2*RSA_DW] = row[0 +: 2*RSA_DW];
          wea_map                        = L'(4'b1100);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lk0_d   = lk0_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ena_d   = 1'b0;
    wea_d   = '0;
    addr_d  = addr_q;
    dina_d  = dina_q;
    done_d  = 1'b0;
    busy_d  = (state_q == StRun) | start_ok;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
          sel_d   = TB_dina_sel;
          lk0_d   = l_k_0;
          base_d  = base_addr;
          len_d   = burst_len;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (beat) begin
          ena_d  = 1'b1;
          wea_d  = wea_map;
          addr_d = base_q + TB_AW'(cnt_q);
          dina_d = dina_map;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      lk0_q   <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      addr_q  <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lk0_q   <= lk0_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      dina_q  <= dina_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TB_ena   = ena_q;
  assign TB_wea   = wea_q;
  assign TB_addra = addr_q;
  assign TB_dina  = dina_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tb_dina_map.sv
// Bench for tb_dina_map: constant vector table, hand-written corner sequences and random bursts
// checked every cycle against a burst-level reference model.
module tb_tb_dina_map;
  localparam int X = 4, L = 4, RSA_DW = 16, TB_AW = 10, LEN_W = 8;
  localparam int DW = X * RSA_DW;

  logic              clk, sys_rst, start, l_k_0, A_C_valid, M_C_valid;
  logic [2:0]        TB_dina_sel;
  logic [TB_AW-1:0]  base_addr;
  logic [LEN_W-1:0]  burst_len;
  logic [DW-1:0]     A_C_dout, M_C_dout;
  logic              TB_ena, busy, done;
  logic [L-1:0]      TB_wea;
  logic [TB_AW-1:0]  TB_addra;
  logic [DW-1:0]     TB_dina;

  tb_dina_map #(.X(X), .L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .TB_dina_sel(TB_dina_sel), .l_k_0(l_k_0),
    .base_addr(base_addr), .burst_len(burst_len), .A_C_dout(A_C_dout), .A_C_valid(A_C_valid),
    .M_C_dout(M_C_dout), .M_C_valid(M_C_valid), .TB_ena(TB_ena), .TB_wea(TB_wea),
    .TB_addra(TB_addra), .TB_dina(TB_dina), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ena, done, busy;
    logic [L-1:0] wea;
    logic [TB_AW-1:0] addr;
    logic [DW-1:0] dina;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic lk0;
    logic [63:0] row;
    logic [63:0] dina;
    logic [3:0] wea;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  exp_t nxt;
  // reference burst state: what the spec says is in flight
  logic             run_on;
  logic [2:0]       b_sel;
  logic             b_lk0;
  logic [TB_AW-1:0] b_base, h_addr;
  logic [DW-1:0]    h_dina;
  int               b_len, b_cnt;
  vec_t             tbl[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mkrow(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Spec-level lane mapping from an array of lanes
  function automatic void map_row(input logic [2:0] sel, input logic lk0, input logic [DW-1:0] r,
                                  output logic [DW-1:0] d, output logic [L-1:0] w);
    logic [15:0] c[4];
    logic [15:0] o[4];
    for (int i = 0; i < 4; i++) begin
      c[i] = r[i*16 +: 16];
      o[i] = '0;
    end
    w = '0;
    case (sel[1:0])
      2'b01: begin for (int i = 0; i < 4; i++) o[i] = c[i]; w = 4'b1111; end
      2'b10: begin for (int i = 0; i < 4; i++) o[i] = c[3-i]; w = 4'b1111; end
      2'b11: begin
        if (lk0) begin o[0] = c[0]; o[1] = c[1]; w = 4'b0011; end
        else begin o[2] = c[0]; o[3] = c[1]; w = 4'b1100; end
      end
      default: ;
    endcase
    d = {o[3], o[2], o[1], o[0]};
  endfunction

  task automatic drive(input logic st, input logic [2:0] sel, input logic lk0,
                       input logic [TB_AW-1:0] base, input logic [LEN_W-1:0] len);
    start = st; TB_dina_sel = sel; l_k_0 = lk0; base_addr = base; burst_len = len;
  endtask

  task automatic rows(input logic av, input logic [DW-1:0] a, input logic mv,
                      input logic [DW-1:0] m);
    A_C_valid = av; A_C_dout = a; M_C_valid = mv; M_C_dout = m;
  endtask

  task automatic clear_model();
    run_on = 1'b0; h_addr = '0; h_dina = '0;
    nxt.ena = 1'b0; nxt.done = 1'b0; nxt.busy = 1'b0;
    nxt.wea = '0; nxt.addr = '0; nxt.dina = '0;
  endtask

  // Predict the next output set from the current inputs, clock once, compare everything
  task automatic cycle();
    logic fin, v, busy_now;
    busy_now = nxt.busy;
    fin = 1'b0;
    nxt.ena = 1'b0; nxt.done = 1'b0; nxt.wea = '0; nxt.addr = h_addr; nxt.dina = h_dina;
    if (run_on) begin
      v = b_sel[2] ? M_C_valid : A_C_valid;
      if (v) begin
        nxt.ena = 1'b1;
        nxt.addr = b_base + TB_AW'(b_cnt);
        map_row(b_sel, b_lk0, b_sel[2] ? M_C_dout : A_C_dout, nxt.dina, nxt.wea);
        h_addr = nxt.addr; h_dina = nxt.dina;
        b_cnt++;
        if (b_cnt == b_len) begin fin = 1'b1; run_on = 1'b0; nxt.done = 1'b1; end
      end
    end else if (start && !busy_now && TB_dina_sel[1:0] != 2'b00 && burst_len != '0) begin
      run_on = 1'b1; b_sel = TB_dina_sel; b_lk0 = l_k_0; b_base = base_addr;
      b_len = int'(burst_len); b_cnt = 0;
    end
    nxt.busy = run_on | fin;
    @(posedge clk); #1;
    check("ena", 64'(TB_ena), 64'(nxt.ena));
    check("busy", 64'(busy), 64'(nxt.busy));
    check("done", 64'(done), 64'(nxt.done));
    check("wea", 64'(TB_wea), 64'(nxt.wea));
    check("addra", 64'(TB_addra), 64'(nxt.addr));
    check("dina", TB_dina, nxt.dina);
  endtask

  task automatic mid_reset();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b0, '0, 1'b0, '0);
    #3 sys_rst = 1'b1;
    #1;
    check("rst_ena", 64'(TB_ena), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wea", 64'(TB_wea), 64'd0);
    check("rst_addra", 64'(TB_addra), 64'd0);
    check("rst_dina", TB_dina, 64'd0);
    clear_model();
    @(posedge clk); #1;
    check("rst_hold_busy", 64'(busy), 64'd0);
    check("rst_hold_done", 64'(done), 64'd0);
    sys_rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3'b001, 1'b0, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 4'b1111};
    tbl[1] = '{3'b010, 1'b0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004, 4'b1111};
    tbl[2] = '{3'b011, 1'b1, 64'h5678_1234_BBBB_AAAA, 64'h0000_0000_BBBB_AAAA, 4'b0011};
    tbl[3] = '{3'b011, 1'b0, 64'h5678_1234_BBBB_AAAA, 64'hBBBB_AAAA_0000_0000, 4'b1100};
    tbl[4] = '{3'b101, 1'b0, 64'h0DDD_0CCC_0BBB_0AAA, 64'h0DDD_0CCC_0BBB_0AAA, 4'b1111};
    tbl[5] = '{3'b111, 1'b1, 64'h5678_1234_BBBB_AAAA, 64'h0000_0000_BBBB_AAAA, 4'b0011};
    tbl[6] = '{3'b110, 1'b0, 64'h0DDD_0CCC_0BBB_0AAA, 64'h0AAA_0BBB_0CCC_0DDD, 4'b1111};

    sys_rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b0, '0, 1'b0, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("init_ena", 64'(TB_ena), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_dina", TB_dina, 64'd0);
    sys_rst = 1'b0;

    // start ignored for dir=00 and for burst_len=0
    rows(1'b1, mkrow(9, 9, 9, 9), 1'b1, mkrow(8, 8, 8, 8));
    drive(1'b1, 3'b000, 1'b0, 10'h005, 8'd3);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 10'h005, 8'd3);
    repeat (3) cycle();
    drive(1'b1, 3'b001, 1'b0, 10'h005, 8'd0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    repeat (2) cycle();

    // constant vector table, one single-beat burst each
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i].sel, tbl[i].lk0, 10'(10'h040 + i), 8'd1);
      rows(1'b0, '0, 1'b0, '0);
      cycle();
      drive(1'b0, 3'b000, 1'b0, '0, '0);
      if (tbl[i].sel[2]) rows(1'b1, ~tbl[i].row, 1'b1, tbl[i].row);
      else rows(1'b1, tbl[i].row, 1'b1, ~tbl[i].row);
      cycle();
      check("tbl_dina", TB_dina, tbl[i].dina);
      check("tbl_wea", 64'(TB_wea), 64'(tbl[i].wea));
      check("tbl_addra", 64'(TB_addra), 64'(10'h040 + i));
      check("tbl_done", 64'(done), 64'd1);
      rows(1'b0, '0, 1'b0, '0);
      cycle();
    end

    // POS burst from A, three consecutive rows
    drive(1'b1, 3'b001, 1'b0, 10'h010, 8'd3);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      rows(1'b1, mkrow(4*i+1, 4*i+2, 4*i+3, 4*i+4), 1'b0, '0);
      cycle();
    end
    check("pos_last_addr", 64'(TB_addra), 64'h012);
    check("pos_last_dina", TB_dina, 64'h000C_000B_000A_0009);
    check("pos_done", 64'(done), 64'd1);
    rows(1'b0, '0, 1'b0, '0);
    cycle();
    check("pos_busy_drop", 64'(busy), 64'd0);

    // NEG from M with a gap, A valid all along
    drive(1'b1, 3'b110, 1'b0, 10'h020, 8'd2);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b1, mkrow(16'hF1, 16'hF2, 16'hF3, 16'hF4), 1'b1, mkrow(1, 2, 3, 4));
    cycle();
    check("neg_row0", TB_dina, 64'h0001_0002_0003_0004);
    rows(1'b1, mkrow(16'hF5, 16'hF6, 16'hF7, 16'hF8), 1'b0, mkrow(7, 7, 7, 7));
    cycle();
    check("neg_gap_ena", 64'(TB_ena), 64'd0);
    rows(1'b1, mkrow(16'hF9, 16'hFA, 16'hFB, 16'hFC), 1'b1, mkrow(5, 6, 7, 8));
    cycle();
    check("neg_row1", TB_dina, 64'h0005_0006_0007_0008);
    rows(1'b0, '0, 1'b0, '0);
    cycle();

    // wrap, start while busy, start in the done cycle
    drive(1'b1, 3'b001, 1'b0, 10'h3FF, 8'd2);
    cycle();
    drive(1'b1, 3'b010, 1'b1, 10'h100, 8'd5);
    rows(1'b1, mkrow(1, 1, 1, 1), 1'b0, '0);
    cycle();
    check("wrap_addr0", 64'(TB_addra), 64'h3FF);
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b1, mkrow(2, 2, 2, 2), 1'b0, '0);
    cycle();
    check("wrap_addr1", 64'(TB_addra), 64'h000);
    drive(1'b1, 3'b001, 1'b0, 10'h100, 8'd1);
    rows(1'b1, mkrow(3, 3, 3, 3), 1'b0, '0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    cycle();
    check("done_cycle_start_ignored", 64'(TB_ena), 64'd0);
    rows(1'b0, '0, 1'b0, '0);
    cycle();

    // reset mid-burst, then a fresh burst at a new base
    drive(1'b1, 3'b001, 1'b0, 10'h200, 8'd4);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b1, mkrow(1, 2, 3, 4), 1'b0, '0);
    repeat (2) cycle();
    mid_reset();
    drive(1'b1, 3'b010, 1'b0, 10'h080, 8'd2);
    cycle();
    drive(1'b0, 3'b000, 1'b0, '0, '0);
    rows(1'b1, mkrow(5, 6, 7, 8), 1'b0, '0);
    cycle();
    check("post_rst_addr", 64'(TB_addra), 64'h080);
    cycle();
    rows(1'b0, '0, 1'b0, '0);
    cycle();

    // random bursts
    for (int n = 0; n < 40; n++) begin
      int k;
      drive(1'b1, {1'($urandom), 2'($urandom)}, 1'($urandom), TB_AW'($urandom),
            LEN_W'($urandom_range(5, 1)));
      rows(1'($urandom), {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});
      cycle();
      k = 0;
      while (run_on && k < 100) begin
        drive(($urandom % 4) == 0, 3'($urandom), 1'($urandom), TB_AW'($urandom),
              LEN_W'($urandom_range(5, 1)));
        rows(($urandom % 3) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
             {$urandom, $urandom});
        cycle();
        k++;
      end
      if (run_on) begin
        n_cmp++; n_fail++;
        $display("FAIL rnd_timeout: burst still open after %0d cycles, expected closed", k);
        clear_model();
      end
      drive(1'($urandom), 3'b001, 1'b0, TB_AW'($urandom), 8'd1);
      rows(1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom});
      cycle();
      drive(1'b0, 3'b000, 1'b0, '0, '0);
      rows(1'($urandom), {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});
      cycle();
      while (run_on) begin
        rows(1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom});
        cycle();
      end
      rows(1'b0, '0, 1'b0, '0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tb_dina_map.md
Name: tb_dina_map

Overview:
- Write-side counterpart of the TB port-A read mapper.
- Captures result rows from the A-path or M-path systolic array output.
- Lane-maps each row: positive, reversed, or half-placed for a new landmark.
- Drives TB port-A write data, per-lane write enables and a burst address counter.
- Sits between the RSA result outputs and the TB BRAM port A write side.

Parameters:
X, 4, systolic array row width in lanes (must equal L)
L, 4, TB word width in lanes (DIR_NEW mapping requires L=4)
RSA_DW, 16, lane data width in bits
TB_AW, 10, TB address width
LEN_W, 8, burst length counter width

Ports:
clk  in  1  system clock
sys_rst  in  1  asynchronous active-high reset
start  in  1  single-cycle burst request
TB_dina_sel  in  3  [2] source (0 = A, 1 = M); [1:0] dir (00 IDLE, 01 POS, 10 NEG, 11 NEW)
l_k_0  in  1  half select for DIR_NEW
base_addr  in  TB_AW  first write address
burst_len  in  LEN_W  number of rows to write
A_C_dout  in  X*RSA_DW  A-path result row
A_C_valid  in  1  A-path row valid
M_C_dout  in  X*RSA_DW  M-path result row
M_C_valid  in  1  M-path row valid
TB_ena  out  1  TB port-A enable
TB_wea  out  L  per-lane write enable
TB_addra  out  TB_AW  write address
TB_dina  out  L*RSA_DW  write data
busy  out  1  burst in progress
done  out  1  one-cycle pulse marking burst completion

Behaviour:
- Reset (asynchronous, any time, including mid-burst): all outputs 0, FSM to IDLE, row counter 0, no done pulse.
- FSM states: IDLE, RUN.
- IDLE -> RUN when start=1, dir!=00 and burst_len!=0.
  - Latch sel, l_k_0, base_addr, burst_len; clear counter.
  - busy=1 from the next cycle.
- start with dir=00 or burst_len=0: ignored; no write, no done, stay IDLE.
- start while busy: ignored; latched fields unchanged.
- RUN beat: the latched source's valid=1 (A_C_valid if sel[2]=0, else M_C_valid).
  - The other source's valid is ignored.
  - Next cycle (latency 1): TB_ena=1, TB_addra=base+cnt (modulo 2^TB_AW, wraps), TB_wea and TB_dina per mapping; cnt increments.
- Valid low in RUN: next cycle TB_ena=0, TB_wea=0; TB_dina and TB_addra hold their last values.
- Mapping (lane i = bits [i*RSA_DW +: RSA_DW]):
  - POS: dina lane i = C lane i; wea=all ones.
  - NEG: dina lane i = C lane X-1-i; wea=all ones.
  - NEW, l_k_0=1: dina lanes 0,1 = C lanes 0,1; lanes 2,3 = 0; wea=4'b0011.
  - NEW, l_k_0=0: dina lanes 2,3 = C lanes 0,1; lanes 0,1 = 0; wea=4'b1100.
- Final beat (cnt = burst_len-1 accepted):
  - done=1 in the same cycle as that beat's write outputs.
  - busy=1 that cycle, busy=0 the next cycle.
  - FSM returns to IDLE with the final accept.
  - A start in the done cycle is ignored (busy still high).
- Beats arriving after completion, or while in IDLE: ignored (TB_ena=0).
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Reset and idle: assert sys_rst mid-clock -> all outputs 0 immediately. Release, then pulse start with dir=00 -> busy stays 0, TB_ena never 1.
- POS burst from A: base=0x010, len=3, A rows {1,2,3,4},{5,6,7,8},{9,10,11,12} on consecutive cycles.
  - Writes at 0x010..0x012 with wea=1111 and identical lane order.
  - done pulses with the 0x012 write; busy drops the next cycle.
- NEG from M with gaps: len=2; M_C_valid pattern 1,0,1; concurrent A_C_valid=1 throughout.
  - Row {1,2,3,4} written as {4,3,2,1}; TB_ena pattern 1,0,1.
  - A data never written.
- NEW: l_k_0=1, row {0xAAAA,0xBBBB,x,x} -> dina {0xAAAA,0xBBBB,0,0}, wea=0011. l_k_0=0 -> dina {0,0,0xAAAA,0xBBBB}, wea=1100.
- Wrap and start-while-busy: base=0x3FF, len=2 -> addresses 0x3FF then 0x000. A second start mid-burst with base=0x100 -> ignored.
- Reset mid-burst: len=4, sys_rst after 2 beats -> outputs 0, no done. A fresh burst afterwards starts its addresses at the new base.
